burst_addr_seq: RTL and testbench
=================================

# burst_addr_seq

Burst address sequencer sitting directly upstream of the memory-side address counter path: accepts one burst request (base physical address, beat count, wrap mode) over a valid/ready handshake and emits one beat address per downstream handshake until the burst completes. Used by cache line-fill and writeback paths to generate incrementing or critical-word-first (wrapping) address streams. It performs the load/advance sequencing itself, so consumers see a clean per-beat valid/ready stream with beat index and last flag.

## Interface

Parameters:
- ADDR_WIDTH, default PADDR_WIDTH (letc_pkg): address width.
- BEAT_BYTES, default 4: bytes per beat; power of two, ≥1.
- MAX_BEATS, default 16: maximum beats per burst; power of two, ≥2.
- CNT_W, derived, $clog2(MAX_BEATS+1): width of beat-count fields.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request offered.
- o_req_ready  out  1  sequencer can accept a request.
- i_req_addr  in  ADDR_WIDTH  burst start address.
- i_req_beats  in  CNT_W  beat count, 1..MAX_BEATS.
- i_req_wrap  in  1  1 = wrapping burst, 0 = incrementing.
- o_beat_valid  out  1  beat address valid.
- i_beat_ready  in  1  consumer takes beat.
- o_beat_addr  out  ADDR_WIDTH  current beat address.
- o_beat_idx  out  CNT_W  beat number within burst, 0-based.
- o_beat_last  out  1  current beat is final beat.
- o_busy  out  1  burst in progress.

## Operation

- States: IDLE, BURST.
- IDLE: o_req_ready=1, o_beat_valid=0. On i_req_valid && o_req_ready: latch start = i_req_addr with low log2(BEAT_BYTES) bits cleared; latch beats (0 coerced to 1; values > MAX_BEATS clamped to MAX_BEATS); latch wrap; beat index := 0; go to BURST.
- BURST: o_beat_valid=1, o_req_ready=0, o_busy=1. o_beat_last = (idx == beats-1).
- Beat handshake (o_beat_valid && i_beat_ready): if last, go to IDLE; else idx += 1 and address advances.
- Incrementing advance: addr + BEAT_BYTES modulo 2^ADDR_WIDTH (carry-out discarded; 0xFFFFFFFC → 0x00000000 at 32-bit).
- Wrapping advance: mask = beats*BEAT_BYTES-1; next = (addr & ~mask) | ((addr + BEAT_BYTES) & mask). Applied only when beats is a power of two; otherwise the burst behaves as incrementing.
- No handshake in BURST: all beat outputs hold stable.
- i_req_valid in BURST is ignored (not accepted).
- Reset (any time, including mid-burst): state → IDLE immediately, burst abandoned, no further beats.

## Timing

- Reset values: o_req_ready=1, o_beat_valid=0, o_beat_addr=0, o_beat_idx=0, o_beat_last=0, o_busy=0.
- o_req_ready and o_beat_valid are decoded from state only; no combinational path from i_beat_ready or i_req_valid to any output.
- Request accepted at edge k → first beat valid in cycle after k (one-cycle latency).
- Last beat handshake at edge m → o_req_ready=1 in cycle after m; next request accepted at the earliest at edge m+1, first beat at m+2 (one idle bubble between bursts).
- With i_beat_ready held high, an N-beat burst occupies N consecutive cycles of o_beat_valid.
- o_beat_addr, o_beat_idx, o_beat_last registered; change only on beat handshake or request acceptance.

## Test plan

- Incrementing: addr 0xDEEF0000, beats 4, wrap 0, ready held 1 → addrs 0xDEEF0000/04/08/0C on 4 consecutive cycles, idx 0..3, last only on idx 3, o_req_ready=1 next cycle.
- Wrapping: addr 0xDEEF0008, beats 4, wrap 1 → 0xDEEF0008, 0xDEEF000C, 0xDEEF0000, 0xDEEF0004; last on 4th.
- Backpressure: beats 2, i_beat_ready low 3 cycles after first valid → addr 0xDEEF0000 held stable, idx 0, no advance; then 0x…00, 0x…04 on release.
- Boundaries: addr 0xFFFFFFFE (misaligned), beats 2, wrap 0 → 0xFFFFFFFC then 0x00000000; beats 0 → single beat with last=1; beats 3 with wrap 1 → incrementing.
- Reset mid-burst: 8-beat burst, assert i_rst_n low after beat 2 → o_beat_valid drops to 0 without waiting for a clock edge, all outputs at reset values, o_req_ready=1; after release a new request (addr 0x1000, beats 1) yields single beat 0x1000.
- Request during burst: second i_req_valid held while beats pending → not accepted until o_req_ready returns; then accepted, first beat one cycle later.

Source files
------------

// File: rtl/burst_addr_seq.sv
// Burst address sequencer: takes one burst request and emits one beat address per
// downstream handshake. Supports incrementing and power-of-two wrapping bursts.
module burst_addr_seq #(
  parameter  int ADDR_WIDTH = 32,  // matches the platform physical address width
  parameter  int BEAT_BYTES = 4,
  parameter  int MAX_BEATS  = 16,
  localparam int CNT_W      = $clog2(MAX_BEATS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [CNT_W-1:0]      i_req_beats,
  input  logic                  i_req_wrap,
  output logic                  o_beat_valid,
  input  logic                  i_beat_ready,
  output logic [ADDR_WIDTH-1:0] o_beat_addr,
  output logic [CNT_W-1:0]      o_beat_idx,
  output logic                  o_beat_last,
  output logic                  o_busy
);

  localparam int OFF_W = $clog2(BEAT_BYTES);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [CNT_W-1:0]      idx_reg;
  logic [CNT_W-1:0]      beats_reg;
  logic                  wrap_reg;
  logic                  last_reg;

  logic                  accept;
  logic                  beat_hs;
  logic [CNT_W-1:0]      beats_eff;
  logic                  beats_pow2;
  logic [CNT_W-1:0]      idx_inc;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_adv;

  assign accept  = i_req_valid && o_req_ready;
  assign beat_hs = o_beat_valid && i_beat_ready;

  // Zero beats means one beat; oversize requests are clamped to the maximum.
  always_comb begin
    beats_eff = i_req_beats;
    if (i_req_beats == '0)
      beats_eff = CNT_W'(1);
    else if (i_req_beats > CNT_W'(MAX_BEATS))
      beats_eff = CNT_W'(MAX_BEATS);
  end

  assign beats_pow2 = (beats_eff & (beats_eff - CNT_W'(1))) == '0;
  assign idx_inc    = idx_reg + CNT_W'(1);
  assign addr_inc   = addr_reg + ADDR_WIDTH'(BEAT_BYTES);
  assign wrap_mask  = (ADDR_WIDTH'(beats_reg) << OFF_W) - ADDR_WIDTH'(1);
  assign addr_adv   = wrap_reg ? ((addr_reg & ~wrap_mask) | (addr_inc & wrap_mask))
                               : addr_inc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BURST;
      BURST:   if (beat_hs && last_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (state_reg == IDLE);
    o_beat_valid = (state_reg == BURST);
    o_busy       = (state_reg == BURST);
  end

  // Non-power-of-two wrap requests are latched as incrementing bursts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_reg  <= '0;
      idx_reg   <= '0;
      beats_reg <= '0;
      wrap_reg  <= 1'b0;
      last_reg  <= 1'b0;
    end else if (accept) begin
      addr_reg  <= i_req_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
      idx_reg   <= '0;
      beats_reg <= beats_eff;
      wrap_reg  <= i_req_wrap && beats_pow2;
      last_reg  <= (beats_eff == CNT_W'(1));
    end else if (beat_hs) begin
      if (last_reg) begin
        last_reg <= 1'b0;
      end else begin
        addr_reg <= addr_adv;
        idx_reg  <= idx_inc;
        last_reg <= (idx_inc == beats_reg - CNT_W'(1));
      end
    end
  end

  assign o_beat_addr = addr_reg;
  assign o_beat_idx  = idx_reg;
  assign o_beat_last = last_reg;

endmodule

// File: tb/tb_burst_addr_seq.sv
// Directed testbench for burst_addr_seq: hand-computed beat streams for incrementing,
// wrapping, backpressure, boundary, reset and overlapping-request cases.
module tb_burst_addr_seq;

  localparam int AW = 32;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [CW-1:0] req_beats = '0;
  logic          req_wrap = 1'b0;
  logic          beat_valid;
  logic          beat_ready = 1'b0;
  logic [AW-1:0] beat_addr;
  logic [CW-1:0] beat_idx;
  logic          beat_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_addr_seq #(.ADDR_WIDTH(AW), .BEAT_BYTES(4), .MAX_BEATS(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_beats  (req_beats),
    .i_req_wrap   (req_wrap),
    .o_beat_valid (beat_valid),
    .i_beat_ready (beat_ready),
    .o_beat_addr  (beat_addr),
    .o_beat_idx   (beat_idx),
    .o_beat_last  (beat_last),
    .o_busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input int n, input logic w);
    @(negedge clk);
    check("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_beats = CW'(n);
    req_wrap  = w;
    @(posedge clk);
    #1 req_valid = 1'b0;
    $display("request addr=0x%08h beats=%0d wrap=%0b", a, n, w);
  endtask

  task automatic expect_beat(input string tag, input logic [31:0] a, input int idx,
                             input logic last);
    @(negedge clk);
    check({tag, ".valid"}, 32'(beat_valid), 32'd1);
    check({tag, ".addr"},  beat_addr, a);
    check({tag, ".idx"},   32'(beat_idx), 32'(idx));
    check({tag, ".last"},  32'(beat_last), 32'(last));
    check({tag, ".busy"},  32'(busy), 32'd1);
    check({tag, ".ready"}, 32'(req_ready), 32'd0);
    $display("beat %s addr=0x%08h idx=%0d last=%0b", tag, beat_addr, beat_idx, beat_last);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check({tag, ".valid"}, 32'(beat_valid), 32'd0);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    check({tag, ".busy"},  32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    check({tag, ".valid"}, 32'(beat_valid), 32'd0);
    check({tag, ".addr"},  beat_addr, 32'd0);
    check({tag, ".idx"},   32'(beat_idx), 32'd0);
    check({tag, ".last"},  32'(beat_last), 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd0);
  endtask

  initial begin
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // incrementing, ready held high
    beat_ready = 1'b1;
    issue(32'hDEEF_0000, 4, 1'b0);
    expect_beat("inc0", 32'hDEEF_0000, 0, 1'b0);
    expect_beat("inc1", 32'hDEEF_0004, 1, 1'b0);
    expect_beat("inc2", 32'hDEEF_0008, 2, 1'b0);
    expect_beat("inc3", 32'hDEEF_000C, 3, 1'b1);
    expect_idle("inc_done");

    // critical-word-first wrap
    issue(32'hDEEF_0008, 4, 1'b1);
    expect_beat("wrap0", 32'hDEEF_0008, 0, 1'b0);
    expect_beat("wrap1", 32'hDEEF_000C, 1, 1'b0);
    expect_beat("wrap2", 32'hDEEF_0000, 2, 1'b0);
    expect_beat("wrap3", 32'hDEEF_0004, 3, 1'b1);
    expect_idle("wrap_done");

    // backpressure: beat 0 holds while ready is low
    beat_ready = 1'b0;
    issue(32'hDEEF_0000, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold.valid", 32'(beat_valid), 32'd1);
      check("bp_hold.addr",  beat_addr, 32'hDEEF_0000);
      check("bp_hold.idx",   32'(beat_idx), 32'd0);
      check("bp_hold.last",  32'(beat_last), 32'd0);
    end
    beat_ready = 1'b1;
    expect_beat("bp1", 32'hDEEF_0004, 1, 1'b1);
    expect_idle("bp_done");

    // misaligned start near top of address space, rollover to zero
    issue(32'hFFFF_FFFE, 2, 1'b0);
    expect_beat("roll0", 32'hFFFF_FFFC, 0, 1'b0);
    expect_beat("roll1", 32'h0000_0000, 1, 1'b1);
    expect_idle("roll_done");

    // zero beats coerced to one
    issue(32'h0000_0100, 0, 1'b0);
    expect_beat("zero0", 32'h0000_0100, 0, 1'b1);
    expect_idle("zero_done");

    // three-beat wrap request behaves as incrementing
    issue(32'h0000_0008, 3, 1'b1);
    expect_beat("np2_0", 32'h0000_0008, 0, 1'b0);
    expect_beat("np2_1", 32'h0000_000C, 1, 1'b0);
    expect_beat("np2_2", 32'h0000_0010, 2, 1'b1);
    expect_idle("np2_done");

    // 20 beats clamped to 16
    issue(32'h0000_2000, 20, 1'b0);
    for (int i = 0; i < 16; i++)
      expect_beat("clamp", 32'h0000_2000 + 32'(4 * i), i, i == 15);
    expect_idle("clamp_done");

    // asynchronous reset mid-burst
    issue(32'h0000_3000, 8, 1'b0);
    expect_beat("rst0", 32'h0000_3000, 0, 1'b0);
    expect_beat("rst1", 32'h0000_3004, 1, 1'b0);
    expect_beat("rst2", 32'h0000_3008, 2, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0000_1000, 1, 1'b0);
    expect_beat("post_rst", 32'h0000_1000, 0, 1'b1);
    expect_idle("post_rst_done");

    // second request held during a burst waits for the idle bubble
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_4000;
    req_beats = CW'(2);
    req_wrap  = 1'b0;
    @(posedge clk);
    #1;
    req_addr  = 32'h0000_5000;
    req_beats = CW'(1);
    expect_beat("ovl_a0", 32'h0000_4000, 0, 1'b0);
    expect_beat("ovl_a1", 32'h0000_4004, 1, 1'b1);
    expect_idle("ovl_gap");
    @(posedge clk);
    #1 req_valid = 1'b0;
    expect_beat("ovl_b0", 32'h0000_5000, 0, 1'b1);
    expect_idle("ovl_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
